// File: rtl/stream_demux.sv
// stream_demux: routes a valid/ready packet stream to one of CHANNELS outputs.
// The destination is taken from in_sel on a packet's first beat and held for
// the rest of the packet. A first beat whose select is out of range causes
// the whole packet to be swallowed, with a one-cycle sel_err pulse.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   in_data/in_sel/in_last/in_valid -> in_ready : input beat handshake
//   out_data/out_last : shared payload of the single output register
//   out_valid/out_ready : per-channel handshake, out_valid is one-hot or zero
//   sel_err         : pulses the cycle after an out-of-range first beat
//   busy            : high while inside a packet (routing or dropping)
module stream_demux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic                in_last,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_last,
  output logic [CHANNELS-1:0] out_valid,
  input  logic [CHANNELS-1:0] out_ready,
  output logic                sel_err,
  output logic                busy
);

  localparam int SEL_N = 1 << SEL_W;
  // One extra bit so that CHANNELS == 2**SEL_W is representable.
  localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(CHANNELS);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DROP} state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     cur_ch_q, cur_ch_d;
  logic [SEL_W-1:0]     out_ch_q, out_ch_d;
  logic [CHANNELS-1:0]  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic                 sel_err_q, sel_err_d;

  logic [SEL_N-1:0]     ready_ext;
  logic                 sel_ok;
  logic                 accept;
  logic                 drain;
  logic                 route;
  logic [SEL_W-1:0]     route_ch;

  // Ready vector padded to the full select range so out_ch_q can index it
  // directly; unused codes read as not-ready (never held in practice).
  generate
    for (genvar gi = 0; gi < SEL_N; gi++) begin : g_ready_ext
      if (gi < CHANNELS) begin : g_used
        assign ready_ext[gi] = out_ready[gi];
      end else begin : g_unused
        assign ready_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign sel_ok   = {1'b0, in_sel} < CH_LIM;
  // Dropping never touches the output register, so it can always take a beat.
  assign in_ready = (state_q == ST_DROP) || !(|out_valid_q) || ready_ext[out_ch_q];
  assign accept   = in_valid && in_ready;
  assign drain    = |(out_valid_q & out_ready);

  always_comb begin
    state_d     = state_q;
    cur_ch_d    = cur_ch_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    sel_err_d   = 1'b0;
    route       = 1'b0;
    route_ch    = cur_ch_q;

    if (drain) begin
      out_valid_d = '0;
    end

    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (sel_ok) begin
            route    = 1'b1;
            route_ch = in_sel;
            cur_ch_d = in_sel;
            state_d  = in_last ? ST_IDLE : ST_BUSY;
          end else begin
            sel_err_d = 1'b1;
            state_d   = in_last ? ST_IDLE : ST_DROP;
          end
        end
        ST_BUSY: begin
          route = 1'b1;
          if (in_last) begin
            state_d = ST_IDLE;
          end
        end
        ST_DROP: begin
          if (in_last) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A new beat overrides the drain clear above: reload with no bubble.
    if (route) begin
      out_data_d = in_data;
      out_last_d = in_last;
      out_ch_d   = route_ch;
      for (int i = 0; i < CHANNELS; i++) begin
        out_valid_d[i] = (route_ch == SEL_W'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_ch_q    <= '0;
      out_ch_q    <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_ch_q    <= cur_ch_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign sel_err   = sel_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_stream_demux.sv
// Testbench for stream_demux. Two instances share one stimulus stream: dut_a
// with 8 channels and dut_b with 6 channels (selects 6 and 7 are out of range).
// A packet-level reference model per instance predicts every output each
// cycle, and a scoreboard matches each downstream transfer against the beats
// the model routed. Directed steps cover the listed scenarios, then a random
// phase exercises arbitrary handshakes and occasional resets.
module tb_stream_demux;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_last;
  logic [7:0] in_data;
  logic [2:0] in_sel;
  logic [7:0] ordy;

  logic       in_ready_a, out_last_a, sel_err_a, busy_a;
  logic [7:0] out_data_a, out_valid_a;
  logic       in_ready_b, out_last_b, sel_err_b, busy_b;
  logic [7:0] out_data_b;
  logic [5:0] out_valid_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stream_demux #(.WIDTH(8), .CHANNELS(8), .SEL_W(3)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready_a), .out_data(out_data_a),
    .out_last(out_last_a), .out_valid(out_valid_a), .out_ready(ordy),
    .sel_err(sel_err_a), .busy(busy_a)
  );

  stream_demux #(.WIDTH(8), .CHANNELS(6), .SEL_W(3)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready_b), .out_data(out_data_b),
    .out_last(out_last_b), .out_valid(out_valid_b), .out_ready(ordy[5:0]),
    .sel_err(sel_err_b), .busy(busy_b)
  );

  // Reference model: packet mode (0 = between packets, 1 = routing to m_cur,
  // 2 = swallowing a bad packet) plus the one beat waiting downstream.
  int         nch [2] = '{8, 6};
  int         m_mode [2];
  int         m_cur [2];
  int         m_hch [2];
  bit         m_hv [2];
  bit         m_hlast [2];
  bit         m_serr [2];
  logic [7:0] m_hdata [2];
  logic [11:0] sb_a [$];
  logic [11:0] sb_b [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_ov(input int d);
    return m_hv[d] ? (8'd1 << m_hch[d]) : 8'd0;
  endfunction

  // A beat can enter unless a held beat is stuck behind a non-ready channel.
  function automatic bit m_rdy(input int d);
    return (m_mode[d] == 2) || !m_hv[d] || (ordy[m_hch[d]] == 1'b1);
  endfunction

  function automatic int idx8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_step(input int d);
    bit acc, xfer, routed;
    int ch;
    acc    = (in_valid == 1'b1) && m_rdy(d);
    xfer   = m_hv[d] && (ordy[m_hch[d]] == 1'b1);
    routed = 1'b0;
    ch     = 0;
    if (rst) begin
      m_mode[d] = 0; m_cur[d] = 0; m_hch[d] = 0; m_hv[d] = 1'b0;
      m_hlast[d] = 1'b0; m_serr[d] = 1'b0; m_hdata[d] = 8'h00;
      if (d == 0) sb_a.delete(); else sb_b.delete();
    end else begin
      m_serr[d] = 1'b0;
      if (acc) begin
        if (m_mode[d] == 0) begin
          if (int'(in_sel) < nch[d]) begin
            routed = 1'b1; ch = int'(in_sel); m_cur[d] = ch;
            m_mode[d] = in_last ? 0 : 1;
          end else begin
            m_serr[d] = 1'b1;
            m_mode[d] = in_last ? 0 : 2;
          end
        end else if (m_mode[d] == 1) begin
          routed = 1'b1; ch = m_cur[d];
          if (in_last) m_mode[d] = 0;
        end else if (in_last) begin
          m_mode[d] = 0;
        end
      end
      if (routed) begin
        m_hv[d] = 1'b1; m_hch[d] = ch; m_hdata[d] = in_data; m_hlast[d] = in_last;
        if (d == 0) sb_a.push_back({3'(ch), in_last, in_data});
        else        sb_b.push_back({3'(ch), in_last, in_data});
      end else if (xfer) begin
        m_hv[d] = 1'b0;
      end
    end
  endtask

  // One clock: pre-edge checks of in_ready and downstream transfers, model
  // update, then registered outputs compared on the falling edge.
  task automatic tick();
    logic [11:0] e;
    #1;
    if (!rst) begin
      chk("a_in_ready", 32'(in_ready_a), 32'(m_rdy(0)));
      chk("b_in_ready", 32'(in_ready_b), 32'(m_rdy(1)));
      if ((out_valid_a & ordy) != 8'h00) begin
        chk("a_sb_depth", 32'(sb_a.size()), 32'd1);
        if (sb_a.size() > 0) begin
          e = sb_a.pop_front();
          chk("a_xfer", 32'({3'(idx8(out_valid_a)), out_last_a, out_data_a}), 32'(e));
        end
      end
      if ((out_valid_b & ordy[5:0]) != 6'h00) begin
        chk("b_sb_depth", 32'(sb_b.size()), 32'd1);
        if (sb_b.size() > 0) begin
          e = sb_b.pop_front();
          chk("b_xfer", 32'({3'(idx8({2'b00, out_valid_b})), out_last_b, out_data_b}), 32'(e));
        end
      end
    end
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
    chk("a_out_valid", 32'(out_valid_a), 32'(m_ov(0)));
    chk("a_out_data",  32'(out_data_a),  32'(m_hdata[0]));
    chk("a_out_last",  32'(out_last_a),  32'(m_hlast[0]));
    chk("a_busy",      32'(busy_a),      32'(m_mode[0] != 0));
    chk("a_sel_err",   32'(sel_err_a),   32'(m_serr[0]));
    chk("b_out_valid", 32'(out_valid_b), 32'(m_ov(1)));
    chk("b_out_data",  32'(out_data_b),  32'(m_hdata[1]));
    chk("b_out_last",  32'(out_last_b),  32'(m_hlast[1]));
    chk("b_busy",      32'(busy_b),      32'(m_mode[1] != 0));
    chk("b_sel_err",   32'(sel_err_b),   32'(m_serr[1]));
  endtask

  task automatic beat(input logic [2:0] sel, input logic [7:0] data, input logic last);
    in_valid = 1'b1; in_sel = sel; in_data = data; in_last = last;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    int serr_cnt;
    rst = 1'b1; in_valid = 1'b0; in_sel = 3'd0; in_data = 8'h00; in_last = 1'b0;
    ordy = 8'hFF;
    for (int i = 0; i < 2; i++) model_step(i);

    // Reset, then in_ready/busy right after it.
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready_a), 32'd1);
    chk("rst_busy",     32'(busy_a),     32'd0);
    chk("rst_out_valid", 32'(out_valid_a), 32'd0);
    idle();

    // Single-beat packets to every channel, one per cycle.
    for (int s = 0; s < 8; s++) begin
      in_valid = 1'b1; in_sel = 3'(s); in_data = 8'(8'hA0 + s); in_last = 1'b1;
      #1;
      chk("single_in_ready", 32'(in_ready_a), 32'd1);
      tick();
      chk("single_valid", 32'(out_valid_a), 32'(8'd1 << s));
      chk("single_data",  32'(out_data_a),  32'(8'hA0 + s));
    end
    idle();

    // 4-beat packet: select is only honoured on the first beat.
    for (int b = 0; b < 4; b++) begin
      beat((b == 0) ? 3'd3 : 3'd5, 8'(8'h30 + b), b == 3);
      chk("pkt4_valid", 32'(out_valid_a), 32'h08);
      chk("pkt4_busy",  32'(busy_a),      32'(b < 3));
    end
    idle();

    // 6-channel instance: select 7 drops a 3-beat packet, then a good packet.
    serr_cnt = 0;
    for (int b = 0; b < 3; b++) begin
      beat(3'd7, 8'(8'h50 + b), b == 2);
      chk("drop_no_valid", 32'(out_valid_b), 32'd0);
      serr_cnt += int'(sel_err_b);
    end
    beat(3'd2, 8'h62, 1'b1);
    serr_cnt += int'(sel_err_b);
    chk("drop_next_valid", 32'(out_valid_b), 32'h04);
    chk("drop_next_data",  32'(out_data_b),  32'h62);
    idle();
    serr_cnt += int'(sel_err_b);
    chk("drop_serr_count", 32'(serr_cnt), 32'd1);

    // Back-pressure on channel 1 for 5 cycles, then streaming resumes.
    ordy = 8'hFD;
    beat(3'd1, 8'h71, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_sel = 3'd1; in_data = 8'h72; in_last = 1'b0;
      #1;
      chk("stall_in_ready", 32'(in_ready_a), 32'd0);
      tick();
      chk("stall_data",  32'(out_data_a),  32'h71);
      chk("stall_valid", 32'(out_valid_a), 32'h02);
    end
    ordy = 8'hFF;
    for (int b = 2; b <= 4; b++) begin
      beat(3'd1, 8'(8'h70 + b), b == 4);
      chk("resume_data",  32'(out_data_a),  32'(8'h70 + b));
      chk("resume_valid", 32'(out_valid_a), 32'h02);
    end
    idle();

    // Reset in the middle of a packet to channel 4.
    beat(3'd4, 8'h81, 1'b0);
    rst = 1'b1;
    beat(3'd4, 8'h82, 1'b0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid_rst_valid",    32'(out_valid_a), 32'd0);
    chk("mid_rst_data",     32'(out_data_a),  32'd0);
    chk("mid_rst_last",     32'(out_last_a),  32'd0);
    chk("mid_rst_busy",     32'(busy_a),      32'd0);
    chk("mid_rst_in_ready", 32'(in_ready_a),  32'd1);
    beat(3'd1, 8'h91, 1'b1);
    chk("post_rst_valid", 32'(out_valid_a), 32'h02);
    chk("post_rst_data",  32'(out_data_a),  32'h91);
    idle();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 149) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_sel   = 3'($urandom);
      in_data  = 8'($urandom);
      in_last  = ($urandom_range(0, 2) == 0);
      ordy     = 8'($urandom) | 8'($urandom);
      tick();
    end
    rst = 1'b0; ordy = 8'hFF;
    idle();
    idle();
    chk("final_a_drained", 32'(out_valid_a), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter WIDTH, default 8, sets the data beat width in bits.
REQ-002 Parameter CHANNELS, default 8, sets the number of output channels (2..256).
REQ-003 Parameter SEL_W, default 3, sets the select width; 2**SEL_W >= CHANNELS shall hold.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port in_data, input, WIDTH bits: input beat payload.
REQ-007 Port in_sel, input, SEL_W bits: destination channel, sampled only on a packet's first beat.
REQ-008 Port in_last, input, 1 bit: marks the final beat of a packet.
REQ-009 Port in_valid, input, 1 bit: input beat present.
REQ-010 Port in_ready, output, 1 bit: block accepts the beat this cycle.
REQ-011 Port out_data, output, WIDTH bits: payload shared by all channels.
REQ-012 Port out_last, output, 1 bit: final-beat marker for the held beat.
REQ-013 Port out_valid, output, CHANNELS bits: one-hot per-channel valid.
REQ-014 Port out_ready, input, CHANNELS bits: per-channel downstream ready.
REQ-015 Port sel_err, output, 1 bit: one-cycle pulse when a packet is dropped for an out-of-range select.
REQ-016 Port busy, output, 1 bit: high while mid-packet (state BUSY or DROP).

Function
REQ-017 Accept = in_valid && in_ready; a beat transfers out on channel k when out_valid[k] && out_ready[k].
REQ-018 A single output register holds the payload, the last flag and the held channel index out_ch; at most one out_valid bit is high.
REQ-019 in_ready = 1 in DROP; otherwise in_ready = !(|out_valid) || out_ready[out_ch], combinational.
REQ-020 An accepted routed beat appears on out_data/out_valid on the next cycle (latency 1); throughput is one beat per cycle while the held channel is ready.
REQ-021 If an output transfer and a new accept occur in the same cycle, the register reloads with the new beat and its channel, with no bubble.
REQ-022 If an output transfer occurs with no accept, out_valid clears to 0 on the next edge.
REQ-023 While out_valid[out_ch]=1 and out_ready[out_ch]=0, out_data, out_last and out_valid are held stable.
REQ-024 out_valid does not depend combinationally on out_ready or in_valid.
REQ-025 FSM states are IDLE, BUSY and DROP.
REQ-026 IDLE, accept with in_sel < CHANNELS: cur_ch <= in_sel and the beat is routed to in_sel; next state is BUSY if in_last=0, else IDLE.
REQ-027 IDLE, accept with in_sel >= CHANNELS: the beat is discarded, the output register is untouched and sel_err pulses on the next cycle; next state is DROP if in_last=0, else IDLE.
REQ-028 BUSY: in_sel is ignored and each accepted beat is routed to cur_ch; accept with in_last=1 returns to IDLE.
REQ-029 DROP: every valid beat is accepted and discarded, producing no output; accept with in_last=1 returns to IDLE.
REQ-030 A new packet may target a channel other than out_ch while the previous packet's last beat is still held; it is accepted only once that held beat transfers (REQ-019).
REQ-031 A single-beat packet (in_last=1 on its first beat) never enters BUSY or DROP.
REQ-032 busy = (state != IDLE).

Reset
REQ-033 When rst=1 at a clock edge: state <= IDLE, cur_ch <= 0, out_ch <= 0, out_valid <= 0, out_data <= 0, out_last <= 0, sel_err <= 0.
REQ-034 During and immediately after reset, in_ready=1 and busy=0.
REQ-035 Reset asserted mid-packet discards the held beat and the partial packet; the next accepted beat is treated as a first beat.

Verification
REQ-036 Defaults, all out_ready=1; send 8 single-beat packets, in_sel=0..7, in_data=8'hA0+sel -> out_valid=(1<<sel) and out_data=8'hA0+sel one cycle after each accept, in_ready held at 1.
REQ-037 4-beat packet, in_sel=3 on beat 1 and in_sel=5 on beats 2-4 -> all 4 beats on out_valid[3], busy=1 from beat 1 through beat 4, busy=0 after the last beat.
REQ-038 CHANNELS=6, SEL_W=3; 3-beat packet with in_sel=7, followed by a 1-beat packet with in_sel=2 -> sel_err pulses exactly once, no out_valid during the 3 dropped beats, the 1-beat packet emerges on out_valid[2].
REQ-039 Packet to channel 1 with out_ready[1]=0 for 5 cycles -> in_ready=0 and out_data stable throughout; when out_ready[1] rises, streaming resumes at 1 beat/cycle with no loss or duplication.
REQ-040 rst pulsed for 1 cycle on beat 2 of a 4-beat packet to channel 4 -> next cycle all outputs 0, busy=0; a following packet with in_sel=1 is routed to channel 1.
